uart_transmitter: RTL
=====================

Name: uart_transmitter

Overview:
8N1 UART transmit side, the counterpart to the on-chip UART receiver on the same serial link.
- Accepts one byte per handshake from the pipeline CPU's peripheral/MMIO logic.
- Serializes the byte LSB-first onto UART_Tx: one start bit, 8 data bits, one stop bit.
- Bit timing is derived from sys_clk by a fixed divider.
- Default timing matches the receiver: 325 clocks × 16 oversample ticks = 5200 clocks per bit (9600 baud at 50 MHz).

Parameters:
- CLKS_PER_BIT, 5200: sys_clk cycles per serial bit. Legal range is ≥2; elaboration fails otherwise.
- STOP_BITS, 1: number of stop-bit periods, 1 or 2. Other values fail elaboration.

Ports:
- sys_clk  input  1  system clock; all logic on posedge.
- sys_rst_n  input  1  asynchronous reset, active low.
- TX_data  input  8  byte to send; sampled only on an accepted TX_en.
- TX_en  input  1  send request; one-cycle or held level both legal.
- TX_status  output  1  1 = idle and ready to accept; 0 = frame in progress.
- UART_Tx  output  1  serial line; idles high.

Behaviour:
- Interface decision: one clock, sys_clk; reset sys_rst_n is asynchronous, active-low.
- Reset values: UART_Tx=1, TX_status=1, state=IDLE, counters=0, shift register=0.
- Reset assertion mid-frame:
  - UART_Tx returns to 1 immediately (asynchronous).
  - The frame is truncated; no partial frame resumes after release.
- Outputs are registered; no combinational path from TX_en or TX_data to UART_Tx or TX_status.
- States:
  - IDLE: UART_Tx=1, TX_status=1.
  - START, DATA, STOP: TX_status=0.
- Accept rule: at a posedge with state=IDLE and TX_en=1:
  - TX_data is latched into the shift register.
  - State goes to START.
  - From the next cycle, UART_Tx=0 and TX_status=0.
- Ignored requests: TX_en while TX_status=0 is ignored; no queuing, no error flag.
- Input stability: TX_data changes after acceptance do not affect the frame in flight.
- Bit timer:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 in each bit; wraps to 0 on the bit boundary.
  - Each line level is held exactly CLKS_PER_BIT cycles.
- START → DATA: after CLKS_PER_BIT cycles. UART_Tx = shift[0], bit index = 0.
- DATA:
  - On each bit boundary, shift right and increment the 3-bit index.
  - After the bit-7 period, go to STOP with UART_Tx=1.
- STOP:
  - Lasts STOP_BITS×CLKS_PER_BIT cycles, tracked by a stop counter.
  - Then go to IDLE; TX_status=1 from the following cycle.
- Frame length: from the first start-bit cycle to the last stop cycle is (9+STOP_BITS)×CLKS_PER_BIT cycles.
- Back-to-back frames:
  - Minimum gap between a stop end and the next start bit is 1 IDLE cycle.
  - TX_en held high sends frames continuously, one accept per IDLE visit.
- Simultaneous events:
  - TX_en together with reset assertion: reset wins.
  - TX_en in the first cycle after reset release is accepted.
- Illegal state encodings recover to IDLE with UART_Tx=1.

Decomposition:
- Shared package uart_pkg, used by both receiver and transmitter:
  - state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - constant UART_DATA_BITS=8;
  - default CLKS_PER_BIT=5200.
- One sub-module: uart_baud_timer.
  - Parameterised by CLKS_PER_BIT.
  - Ports: clear, run, bit_done pulse.
  - Reusable later by a receiver rewrite.
- The FSM, shift register and stop counter stay in uart_transmitter.

Test Plan:
All cases use CLKS_PER_BIT=16 and STOP_BITS=1 unless stated.
1. Reset, then TX_data=8'hA5, TX_en pulse 1 cycle.
   - UART_Tx sequence, 16 cycles each: 0,1,0,1,0,0,1,0,1,1.
   - TX_status is 0 for exactly 160 cycles, then 1.
2. Accept, then change TX_data to 8'h00 and pulse TX_en at cycle 40.
   - The frame is still 8'hA5; the second request is ignored.
   - The line stays 1 after the stop bit.
3. TX_en held high with TX_data=8'h55 for 3 frames.
   - Three identical frames.
   - Each start bit begins exactly 161 cycles after the previous one.
   - The sampling bench model (the existing receiver instance at matching rate) reports 8'h55 three times.
4. Assert sys_rst_n=0 mid-DATA at cycle 70 (asynchronous, between edges).
   - UART_Tx=1 and TX_status=1 immediately.
   - After release, a send of 8'h3C produces a clean full frame.
5. STOP_BITS=2, TX_data=8'hFF.
   - Start 0 for 16 cycles, then 1 for 160 cycles.
   - TX_status low for 176 cycles.
6. Default CLKS_PER_BIT=5200 looped back into the existing receiver, bytes 8'h00, 8'hFF, 8'h81.
   - RX_data matches each byte.
   - RX_status pulses once per frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver on this serial link.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS       = 8;
    // 325 clocks x 16 oversample ticks: 9600 baud from a 50 MHz sys_clk.
    localparam int DEFAULT_CLKS_PER_BIT = 5200;

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts sys_clk cycles while running and pulses bit_done on
// the last cycle of each bit period.
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_bit_done
);

    localparam int            W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_baud_timer: CLKS_PER_BIT must be at least 2");
    end

    logic [W-1:0] r_count;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_bit_done = i_run && !i_clear && (r_count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts one byte per TX_en while idle and shifts it out
// LSB-first framed by a start bit and STOP_BITS stop bits.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [UART_DATA_BITS-1:0] TX_data,
    input  logic                      TX_en,
    output logic                      TX_status,
    output logic                      UART_Tx,
    output logic [1:0]                o_dbg_state
);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] LAST_IDX  = 3'(UART_DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t               r_state;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [2:0]                r_bit_idx;
    logic                      r_stop_cnt;
    logic                      w_bit_done;
    logic                      w_accept;
    logic                      w_run;

    // TX_en is honoured only in IDLE; requests during a frame are dropped.
    assign w_accept    = (r_state == IDLE) && TX_en;
    assign w_run       = (r_state != IDLE);
    assign o_dbg_state = r_state;

    uart_baud_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_timer (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i_clear    (w_accept),
        .i_run      (w_run),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            UART_Tx    <= 1'b1;
            TX_status  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    UART_Tx   <= 1'b1;
                    TX_status <= 1'b1;
                    if (TX_en) begin
                        r_shift   <= TX_data;
                        r_state   <= START;
                        UART_Tx   <= 1'b0;
                        TX_status <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_state   <= DATA;
                        r_bit_idx <= '0;
                        UART_Tx   <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_state    <= STOP;
                            r_stop_cnt <= 1'b0;
                            UART_Tx    <= 1'b1;
                        end else begin
                            // Present the next bit while shifting it down to position 0.
                            r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                            UART_Tx   <= r_shift[1];
                        end
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        if (r_stop_cnt == STOP_LAST) begin
                            r_state   <= IDLE;
                            TX_status <= 1'b1;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    UART_Tx   <= 1'b1;
                    TX_status <= 1'b1;
                end
            endcase
        end
    end

endmodule
